// File: rtl/telemetry_ingress_arbiter.sv
// Round-robin ingress arbiter for the telemetry backpressure queue, with congestion throttle and drain stop.
// Define TELEM_ARB_STARVE_GUARD_EN to build the low-priority starvation guard.
module telemetry_ingress_arbiter #(
    parameter int  N_REQ        = 4,
    parameter int  DATA_W       = 8,
    parameter int  LEVEL_W      = 8,
    parameter int  HI_THRESH    = 192,
    parameter int  LO_THRESH    = 64,
    parameter int  STARVE_LIMIT = 15,
    localparam int SRC_W        = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          req_pri_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      out_valid_o,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [SRC_W-1:0]          out_src_o,
    input  logic                      out_ready_i,
    input  logic [LEVEL_W-1:0]        queue_level_i,
    input  logic                      congestion_i,
    output logic                      throttle_o,
    output logic [1:0]                arb_state_o
);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] HI_LVL     = LEVEL_W'(HI_THRESH);
    localparam logic [LEVEL_W-1:0] LO_LVL     = LEVEL_W'(LO_THRESH);

    if (N_REQ < 2 || N_REQ > 8 || LO_THRESH >= HI_THRESH || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("telemetry_ingress_arbiter: illegal parameter set");
    end

    // state       | meaning
    // ST_NORMAL   | all valid sources compete round-robin
    // ST_THROTTLE | only high-priority sources compete (plus starving ones when guarded)
    // ST_DRAIN    | queue saturated, no grants; held payload still drains
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_THROTTLE = 2'b01,
        ST_DRAIN    = 2'b10
    } arb_state_e;

    arb_state_e              state_q, state_d;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic [SRC_W-1:0]        out_src_q, out_src_d;

    logic                    slot_free;
    logic [N_REQ-1:0]        eligible;
    logic [N_REQ-1:0]        starving;
    logic                    grant_any;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        cand;

    function automatic logic [SRC_W-1:0] wrap_idx(input int base, input int off);
        return SRC_W'((base + off) % N_REQ);
    endfunction

    assign slot_free = !out_valid_q || out_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (queue_level_i == LEVEL_FULL) begin
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (queue_level_i >= HI_LVL || congestion_i) state_d = ST_THROTTLE;
                end
                ST_THROTTLE: begin
                    if (queue_level_i <= LO_LVL && !congestion_i) state_d = ST_NORMAL;
                end
                ST_DRAIN: begin
                    if (queue_level_i < HI_LVL) state_d = ST_THROTTLE;
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    // A starving source overrides round-robin order; the descending loop leaves the lowest index.
    always_comb begin
        eligible  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        case (state_q)
            ST_NORMAL:   eligible = req_valid_i;
            ST_THROTTLE: eligible = req_valid_i & req_pri_i;
            default:     eligible = '0;
        endcase
        if (rst_n && slot_free) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (starving[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
            for (int k = 0; k < N_REQ; k++) begin
                cand = wrap_idx(int'(rr_ptr_q), k);
                if (!grant_any && eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_any) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_any) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
            out_src_d   = grant_idx;
            rr_ptr_d    = wrap_idx(int'(grant_idx), 1);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef TELEM_ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q [N_REQ];
    logic [CNT_W-1:0] starve_cnt_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starving[i] = (state_q == ST_THROTTLE) && req_valid_i[i] && !req_pri_i[i]
                          && (starve_cnt_q[i] == CNT_MAX);
        end
    end

    // Counters saturate at the limit and hold through DRAIN.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starve_cnt_d[i] = starve_cnt_q[i];
            if (state_q == ST_NORMAL || !req_valid_i[i] || req_pri_i[i]
                || (grant_any && grant_idx == SRC_W'(i))) begin
                starve_cnt_d[i] = '0;
            end else if (state_q == ST_THROTTLE && starve_cnt_q[i] != CNT_MAX) begin
                starve_cnt_d[i] = starve_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst_n) begin
                starve_cnt_q[i] <= '0;
            end else begin
                starve_cnt_q[i] <= starve_cnt_d[i];
            end
        end
    end
`else
    assign starving = '0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign arb_state_o = state_q;
    assign throttle_o  = congestion_i || (rst_n && state_q != ST_NORMAL);

endmodule
